// File: rtl/coregpio_apb_pkg.sv
// Shared definitions for the CoreGPIO APB3 initiator.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
//
// Contents: initiator FSM state enum, CoreGPIO register offsets, and the
// timeout counter width helper. The optional timeout is enabled with the
// macro COREGPIO_APB_INIT_TIMEOUT_EN.
package coregpio_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  // CoreGPIO register map (byte offsets on PADDR)
  localparam logic [7:0] GPIO_CONFIG_BASE   = 8'h00;
  localparam logic [7:0] GPIO_CONFIG_STRIDE = 8'h04;
  localparam logic [7:0] GPIO_IRQ           = 8'h80;
  localparam logic [7:0] GPIO_IN            = 8'h90;
  localparam logic [7:0] GPIO_OUT           = 8'hA0;

  // Address of the CONFIG register for GPIO bit 'idx'
  function automatic logic [7:0] gpio_config_addr(input int unsigned idx);
    return GPIO_CONFIG_BASE + 8'(idx * 4);
  endfunction

  // Counter width for a timeout of 'cycles'; never narrower than one bit
  function automatic int unsigned tmo_ctr_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/coregpio_apb_timeout_ctr.sv
// ACCESS-phase stall counter that flags when a transfer has waited too long.
// Latency: expire is combinational from enable and the registered count.
// Backpressure: none; counts only while enable (ACCESS with PREADY low) is high.
//
// Ports: SYSCLK_apb/PRESETN clock and async active-low reset; clear zeroes the
// count; enable advances it; expire is high on the stall cycle where the count
// has reached TIMEOUT_CYCLES-1. Present only when COREGPIO_APB_INIT_TIMEOUT_EN
// is defined.
`ifdef COREGPIO_APB_INIT_TIMEOUT_EN
module coregpio_apb_timeout_ctr
  import coregpio_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic SYSCLK_apb,
  input  logic PRESETN,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = tmo_ctr_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign expire = enable && (r_count == LAST);

  // Hold at LAST on expiry so the count can never wrap
  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expire) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/coregpio_apb_initiator.sv
// APB3 initiator: one command in, one single APB transfer out, one response back.
// Latency: accept cycle k -> PSEL k+1, PENABLE k+2, RSP_VALID k+3 plus one per wait state.
// Backpressure: CMD_READY only in IDLE; response held in RESP until RSP_READY.
//
// Ports: SYSCLK_apb/PRESETN clock and async active-low reset; CMD_* command
// handshake; RSP_* response handshake; PSEL/PENABLE/PWRITE/PADDR/PWDATA and
// PRDATA/PREADY/PSLVERR form the APB3 initiator side. Optional stall timeout
// is enabled by defining COREGPIO_APB_INIT_TIMEOUT_EN.
module coregpio_apb_initiator
  import coregpio_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  SYSCLK_apb,
  input  logic                  PRESETN,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("coregpio_apb_initiator: illegal DATA_WIDTH or TIMEOUT_CYCLES");
  end

  apb_state_t            r_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  // Decoded from state only, so no input reaches an output combinationally
  assign CMD_READY = (r_state == ST_IDLE);

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;

`ifdef COREGPIO_APB_INIT_TIMEOUT_EN
  logic w_expire;
  logic r_rsp_tmo;

  assign RSP_TIMEOUT = r_rsp_tmo;

  // SETUP is the only way into ACCESS, so clearing there restarts every transfer
  coregpio_apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .SYSCLK_apb(SYSCLK_apb),
    .PRESETN   (PRESETN),
    .clear     (r_state == ST_SETUP),
    .enable    ((r_state == ST_ACCESS) && !PREADY),
    .expire    (w_expire)
  );
`else
  assign RSP_TIMEOUT = 1'b0;
`endif

  always_ff @(posedge SYSCLK_apb or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef COREGPIO_APB_INIT_TIMEOUT_EN
      r_rsp_tmo   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (CMD_VALID) begin
            r_pwrite <= CMD_WRITE;
            r_paddr  <= CMD_ADDR;
            r_pwdata <= CMD_WDATA;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A slave completing on the expiry cycle takes priority over the abort
          if (PREADY) begin
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
`ifdef COREGPIO_APB_INIT_TIMEOUT_EN
            r_rsp_tmo   <= 1'b0;
`endif
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
`ifdef COREGPIO_APB_INIT_TIMEOUT_EN
          else if (w_expire) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_tmo   <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coregpio_apb_initiator.sv
// Self-checking bench for coregpio_apb_initiator with a scoreboard of expected responses.
// Latency: checks k+1/k+2/k+3+waits timing of every transfer against the accept cycle.
// Backpressure: exercises held responses with a pending command and RSP_READY low.
//
// Build with COREGPIO_APB_INIT_TIMEOUT_EN defined to cover the timeout path.
module tb_coregpio_apb_initiator;
  import coregpio_apb_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          SYSCLK_apb = 1'b0;
  logic          PRESETN    = 1'b0;
  logic          CMD_VALID  = 1'b0;
  logic          CMD_READY;
  logic          CMD_WRITE  = 1'b0;
  logic [AW-1:0] CMD_ADDR   = '0;
  logic [DW-1:0] CMD_WDATA  = '0;
  logic          RSP_VALID;
  logic          RSP_READY  = 1'b1;
  logic [DW-1:0] RSP_RDATA;
  logic          RSP_ERR;
  logic          RSP_TIMEOUT;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA  = '0;
  logic          PREADY  = 1'b0;
  logic          PSLVERR = 1'b0;

  coregpio_apb_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .SYSCLK_apb(SYSCLK_apb), .PRESETN(PRESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 SYSCLK_apb = ~SYSCLK_apb;

  int cyc = 0;
  always @(posedge SYSCLK_apb) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            n_acc;
    int            k;
  } exp_t;

  exp_t sb[$];

  // APB slave model: ready after cfg_waits stall cycles; data/error only on the ready cycle
  int            cfg_waits = 0;
  logic [DW-1:0] cfg_rdata = '0;
  logic          cfg_err   = 1'b0;
  int            acc       = 0;

  always @(negedge SYSCLK_apb) begin
    if (PSEL && PENABLE) begin
      PREADY  = (acc == cfg_waits);
      PRDATA  = PREADY ? cfg_rdata : ~cfg_rdata;
      PSLVERR = PREADY && cfg_err;
      acc++;
    end else begin
      acc     = 0;
      PREADY  = 1'b0;
      PRDATA  = '0;
      PSLVERR = 1'b0;
    end
  end

  // Response monitor: compares every RESP cycle against the scoreboard head
  int   pen_cnt  = 0;
  int   rise_cyc = 0;
  logic rv_q     = 1'b0;
  exp_t e_mon;

  always @(negedge SYSCLK_apb) begin
    if (!PRESETN) begin
      pen_cnt = 0;
      rv_q    = 1'b0;
    end else begin
      if (PSEL && PENABLE) pen_cnt++;
      if (RSP_VALID) begin
        if (!rv_q) rise_cyc = cyc;
        check_val("cmd_ready_in_resp", 64'(CMD_READY), 64'd0);
        check_val("psel_in_resp", 64'(PSEL), 64'd0);
        if (sb.size() == 0) begin
          check_val("rsp_unexpected", 64'(sb.size()), 64'd1);
        end else begin
          e_mon = sb[0];
          check_val("rsp_rdata", 64'(RSP_RDATA), 64'(e_mon.rdata));
          check_val("rsp_err", 64'(RSP_ERR), 64'(e_mon.err));
          check_val("rsp_timeout", 64'(RSP_TIMEOUT), 64'(e_mon.tmo));
          check_val("rsp_latency", 64'(rise_cyc - e_mon.k), 64'(e_mon.n_acc + 2));
          check_val("access_cycles", 64'(pen_cnt), 64'(e_mon.n_acc));
          if (RSP_READY) begin
            void'(sb.pop_front());
            pen_cnt = 0;
          end
        end
      end
      rv_q = RSP_VALID;
    end
  end

  task automatic tick();
    @(posedge SYSCLK_apb);
    #2;
  endtask

  // Issue one command, push its expected response, check SETUP and first ACCESS cycle
  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input logic [DW-1:0] rdata, input logic err,
                      output int k);
    exp_t e;
    int   n;
    tick();
    n = 0;
    while (PSEL && n < 300) begin
      tick();
      n++;
    end
    cfg_waits = waits;
    cfg_rdata = rdata;
    cfg_err   = err;
    CMD_WRITE = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = wdata;
    CMD_VALID = 1'b1;
    k = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge SYSCLK_apb);
      if (CMD_READY) begin
        k = cyc;
        break;
      end
    end
    if (k < 0) begin
      check_val("accept_bound", 64'(k), 64'(cyc));
      CMD_VALID = 1'b0;
      return;
    end
    e.n_acc = waits + 1;
    e.rdata = wr ? '0 : rdata;
    e.err   = err;
    e.tmo   = 1'b0;
`ifdef COREGPIO_APB_INIT_TIMEOUT_EN
    if (waits >= TMO) begin
      e.n_acc = TMO;
      e.rdata = '0;
      e.err   = 1'b1;
      e.tmo   = 1'b1;
    end
`endif
    e.k = k;
    sb.push_back(e);
    tick();
    CMD_VALID = 1'b0;
    @(negedge SYSCLK_apb);
    check_val("setup_psel", 64'(PSEL), 64'd1);
    check_val("setup_penable", 64'(PENABLE), 64'd0);
    check_val("setup_paddr", 64'(PADDR), 64'(addr));
    check_val("setup_pwrite", 64'(PWRITE), 64'(wr));
    check_val("setup_pwdata", 64'(PWDATA), 64'(wdata));
    @(negedge SYSCLK_apb);
    check_val("access_psel", 64'(PSEL), 64'd1);
    check_val("access_penable", 64'(PENABLE), 64'd1);
    check_val("access_paddr", 64'(PADDR), 64'(addr));
    check_val("access_pwdata", 64'(PWDATA), 64'(wdata));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check_val("drain", 64'(sb.size()), 64'd0);
  endtask

  // Assert reset mid-transfer and check every output collapses immediately
  task automatic apply_reset();
    PRESETN = 1'b0;
    #1;
    check_val("rst_psel", 64'(PSEL), 64'd0);
    check_val("rst_penable", 64'(PENABLE), 64'd0);
    check_val("rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    check_val("rst_cmd_ready", 64'(CMD_READY), 64'd1);
    check_val("rst_paddr", 64'(PADDR), 64'd0);
    check_val("rst_pwrite", 64'(PWRITE), 64'd0);
    sb.delete();
    repeat (3) tick();
    PRESETN = 1'b1;
  endtask

  initial begin
    int k1, k2, kb, rr_cyc, n;

    // Reset state
    #3;
    check_val("init_cmd_ready", 64'(CMD_READY), 64'd1);
    check_val("init_psel", 64'(PSEL), 64'd0);
    check_val("init_penable", 64'(PENABLE), 64'd0);
    check_val("init_pwrite", 64'(PWRITE), 64'd0);
    check_val("init_paddr", 64'(PADDR), 64'd0);
    check_val("init_pwdata", 64'(PWDATA), 64'd0);
    check_val("init_rsp_valid", 64'(RSP_VALID), 64'd0);
    check_val("init_rsp_rdata", 64'(RSP_RDATA), 64'd0);
    check_val("init_rsp_err", 64'(RSP_ERR), 64'd0);
    check_val("init_rsp_timeout", 64'(RSP_TIMEOUT), 64'd0);
    repeat (3) tick();
    PRESETN = 1'b1;
    tick();

    // Zero-wait write, wait-state read, slave errors on read and write
    send(1'b1, GPIO_OUT, 32'h0000_00FF, 0, 32'h1111_2222, 1'b0, k1);
    wait_done();
    send(1'b0, GPIO_IN, 32'h0, 2, 32'h0000_005A, 1'b0, k1);
    wait_done();
    send(1'b0, GPIO_IRQ, 32'h0, 0, 32'h1234_5678, 1'b1, k1);
    wait_done();
    send(1'b1, gpio_config_addr(3), 32'hA5A5_0001, 1, 32'hFFFF_FFFF, 1'b1, k1);
    wait_done();

    // Back-to-back commands with RSP_READY high are four cycles apart
    send(1'b0, GPIO_IN, 32'h0, 0, 32'h0000_0011, 1'b0, k1);
    send(1'b0, GPIO_OUT, 32'h0, 0, 32'h0000_0022, 1'b0, k2);
    check_val("spacing", 64'(k2 - k1), 64'd4);
    wait_done();

    // Backpressure: response held 5 cycles while the next command waits
    RSP_READY = 1'b0;
    send(1'b0, GPIO_IN, 32'h0, 1, 32'h0000_0077, 1'b0, k1);
    rr_cyc = 0;
    fork
      send(1'b1, GPIO_OUT, 32'h0000_0003, 0, 32'h0, 1'b0, kb);
      begin
        n = 0;
        while (!RSP_VALID && n < 50) begin
          tick();
          n++;
        end
        repeat (5) tick();
        RSP_READY = 1'b1;
        rr_cyc = cyc;
      end
    join
    check_val("bp_next_accept", 64'(kb - rr_cyc), 64'd1);
    wait_done();

`ifdef COREGPIO_APB_INIT_TIMEOUT_EN
    // Stuck slave aborts after TMO access cycles; ready on the last cycle still completes
    send(1'b0, GPIO_IN, 32'h0, 1000, 32'hDEAD_BEEF, 1'b0, k1);
    wait_done();
    send(1'b0, GPIO_IN, 32'h0, TMO - 1, 32'h0000_00C3, 1'b0, k1);
    wait_done();
`else
    // Without the timeout, a stuck slave holds the transfer indefinitely
    send(1'b0, GPIO_IN, 32'h0, 1000, 32'hDEAD_BEEF, 1'b0, k1);
    repeat (110) tick();
    check_val("hang_penable", 64'(PENABLE), 64'd1);
    check_val("hang_rsp_valid", 64'(RSP_VALID), 64'd0);
    apply_reset();
`endif

    // Reset in the second ACCESS cycle drops the transfer; next write runs normally
    send(1'b0, GPIO_IN, 32'h0, 1000, 32'hCAFE_F00D, 1'b0, k1);
    tick();
    apply_reset();
    send(1'b1, GPIO_OUT, 32'h0000_00FF, 0, 32'h0, 1'b0, k1);
    wait_done();

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/coregpio_apb_initiator.md
# coregpio_apb_initiator

Synthesizable APB3 initiator that turns a simple command/response handshake into single APB transfers on the CoreGPIO register bus. It is the requesting end of the interface the CoreGPIO slave answers, for use by on-chip sequencers and the Mi-V subsystem glue. It issues one transfer at a time and honours PREADY wait states and PSLVERR. A compile-time timeout can abort transfers that hang.

## Interface
- ADDR_WIDTH, 8: PADDR/CMD_ADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width; legal values 8, 16, 32.
- TIMEOUT_CYCLES, 16: ACCESS cycles with PREADY low before abort; range 2..65535. Used only when the timeout macro is defined.

Ports:
- SYSCLK_apb  in  1  clock; all logic on the rising edge.
- PRESETN  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when high with CMD_VALID.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_WIDTH  target register address.
- CMD_WDATA  in  DATA_WIDTH  write data.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed when high with RSP_VALID.
- RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes and aborts.
- RSP_ERR  out  1  PSLVERR seen, or timeout.
- RSP_TIMEOUT  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH.
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- CMD_READY = (state == IDLE). It reads 1 during and after reset.
- IDLE:
  - On CMD_VALID & CMD_READY, register CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA, then go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0.
  - Always go to ACCESS next cycle.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - Stay while PREADY=0.
  - On PREADY=1: RSP_RDATA <= PWRITE ? 0 : PRDATA; RSP_ERR <= PSLVERR; RSP_TIMEOUT <= 0; go to RESP.
- RESP:
  - PSEL=PENABLE=0, RSP_VALID=1.
  - Response fields are held stable until RSP_READY=1, then go to IDLE.
- PADDR/PWRITE/PWDATA change only on command accept. They hold their last value outside transfers.
- PRDATA and PSLVERR are sampled only in ACCESS with PREADY=1.
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, RSP_VALID, RSP_RDATA, RSP_ERR and RSP_TIMEOUT are all 0. CMD_READY is 1.
- PRESETN asserted in any state:
  - All outputs take reset values immediately (asynchronous); the in-flight command is dropped with no response.
  - After deassertion the first command proceeds normally.

## Timing
- Command accepted on edge k:
  - PSEL high from k+1 (SETUP).
  - PENABLE high from k+2 (ACCESS).
  - With zero wait states, RSP_VALID is high from k+3.
- Each PREADY-low cycle in ACCESS adds one cycle.
- Minimum spacing between accepted commands is 4 cycles: accept, SETUP, ACCESS, RESP with RSP_READY held high.
- All outputs are registered except CMD_READY, which is decoded from state registers only (no input-to-output combinational path).

## Configuration
- Macro COREGPIO_APB_INIT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - On the ACCESS cycle where count == TIMEOUT_CYCLES-1 and PREADY=0, the transfer aborts: go to RESP with RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0. PSEL/PENABLE drop on the next edge.
  - PREADY=1 on that same cycle wins and the transfer completes normally.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - RSP_TIMEOUT is tied to 0.

## Structure
- Package coregpio_apb_pkg:
  - FSM state enum.
  - CoreGPIO register offset constants: CONFIG base 0x00 (stride 4), IRQ 0x80, IN 0x90, OUT 0xA0.
  - Timeout counter width: $clog2(TIMEOUT_CYCLES).
- Sub-module coregpio_apb_timeout_ctr, instantiated only under the macro. Ports: clear, enable, expire.

## Test plan
- Write: 0x000000FF to 0xA0, PREADY=1 → PSEL at k+1, PENABLE at k+2, PWDATA=0xFF stable both cycles; RSP_VALID at k+3, RSP_ERR=0, RSP_RDATA=0.
- Wait-state read: 0x90 with PREADY low 2 cycles, PRDATA=0x5A → PENABLE high 3 cycles, RSP_RDATA=0x5A, RSP_VALID at k+5.
- Slave error: read 0x80 with PSLVERR=1 on the ready cycle → RSP_ERR=1, RSP_TIMEOUT=0, RSP_RDATA equals PRDATA.
- Timeout: macro defined, TIMEOUT_CYCLES=4, PREADY stuck 0 → exactly 4 ACCESS cycles, then RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0. Without the macro, PENABLE stays high for more than 100 cycles.
- Backpressure: RSP_READY low 5 cycles with CMD_VALID high → RSP fields stable, CMD_READY=0, no new PSEL. The next transfer starts 1 cycle after RSP_READY rises.
- Reset mid-ACCESS: PRESETN low → PSEL/PENABLE/RSP_VALID 0 immediately, CMD_READY=1. After release, a write to 0xA0 completes with the k+3 response timing.
